// File: rtl/gba_timer_pkg.sv
// ---------------------------------------------------------------------------
// gba_timer_pkg
// Shared types and constants for the GBA timer block (TM0-TM3).
//   prescale_e   : TMxCNT_H[1:0] divider select (/1, /64, /256, /1024)
//   timer_ctrl_t : decoded TMxCNT_H control fields
//   ps_div_m1()  : terminal count of the prescale counter for a divider
//   ctrl_to_bits(): packs the control struct back into the CNT_H layout
// ---------------------------------------------------------------------------
package gba_timer_pkg;

  typedef enum logic [1:0] {
    PS_1    = 2'd0,
    PS_64   = 2'd1,
    PS_256  = 2'd2,
    PS_1024 = 2'd3
  } prescale_e;

  // TMxCNT_H bit positions
  localparam int PS_LSB    = 0;
  localparam int CU_BIT    = 2;
  localparam int IRQ_BIT   = 6;
  localparam int START_BIT = 7;

  // Bits of TMxCNT_H that hold state; everything else reads as 0
  localparam logic [15:0] CNT_H_WMASK = 16'h00C7;

  // Prescale counter must reach 1023 for the /1024 setting
  localparam int PS_W = 10;

  typedef struct packed {
    logic      start;
    logic      irq_en;
    logic      count_up;
    prescale_e prescale;
  } timer_ctrl_t;

  function automatic logic [PS_W-1:0] ps_div_m1(input prescale_e ps);
    case (ps)
      PS_1:    return 10'd0;
      PS_64:   return 10'd63;
      PS_256:  return 10'd255;
      default: return 10'd1023;
    endcase
  endfunction

  function automatic logic [15:0] ctrl_to_bits(input timer_ctrl_t c);
    logic [15:0] b;
    b                 = '0;
    b[PS_LSB +: 2]    = c.prescale;
    b[CU_BIT]         = c.count_up;
    b[IRQ_BIT]        = c.irq_en;
    b[START_BIT]      = c.start;
    return b;
  endfunction

endpackage

// File: rtl/gba_timer_channel.sv
// ---------------------------------------------------------------------------
// gba_timer_channel
// One GBA timer channel: reload register, live counter, CNT_H control,
// prescaler and cascade (count-up) input.
// Optional: GBA_TIMER_START_DELAY_EN adds a 2-cycle counting holdoff after
// a 0->1 start (counter still loads at the write edge).
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   wr_lo_i        : write strobe for CNT_L (reload register)
//   wr_hi_i        : write strobe for CNT_H (control)
//   wr_data_i      : write data
//   cascade_i      : same-cycle overflow of the previous channel
//   count_o        : live counter value
//   cnt_h_o        : CNT_H readback
//   ovf_o          : combinational overflow this cycle (feeds next channel)
//   irq_o          : registered one-cycle overflow interrupt pulse
// ---------------------------------------------------------------------------
module gba_timer_channel
  import gba_timer_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit CASCADE_EN = 1'b1  // ch0 has no predecessor: count-up ignored
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [CNT_W-1:0] wr_data_i,
  input  logic             cascade_i,
  output logic [CNT_W-1:0] count_o,
  output logic [15:0]      cnt_h_o,
  output logic             ovf_o,
  output logic             irq_o
);

  timer_ctrl_t      ctrl_q, ctrl_d, wr_ctrl;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             irq_q, irq_d;

  logic starting, stopping, run, counting, use_casc, ps_tick, tick, ovf;

  always_comb begin
    wr_ctrl          = '0;
    wr_ctrl.prescale = prescale_e'(wr_data_i[PS_LSB +: 2]);
    wr_ctrl.count_up = wr_data_i[CU_BIT];
    wr_ctrl.irq_en   = wr_data_i[IRQ_BIT];
    wr_ctrl.start    = wr_data_i[START_BIT];
  end

  assign starting = wr_hi_i &&  wr_ctrl.start && !ctrl_q.start;
  // A stop written on the same edge as a tick wins: no count, no overflow.
  assign stopping = wr_hi_i && !wr_ctrl.start;
  assign run      = ctrl_q.start && !stopping;

`ifdef GBA_TIMER_START_DELAY_EN
  logic [1:0] dly_q, dly_d;
  assign counting = run && (dly_q == 2'd0);

  always_comb begin
    dly_d = dly_q;
    if (starting) begin
      dly_d = 2'd2;
    end else if (dly_q != 2'd0) begin
      dly_d = dly_q - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dly_q <= 2'd0;
    end else begin
      dly_q <= dly_d;
    end
  end
`else
  assign counting = run;
`endif

  // Current (pre-write) control is used this edge; CNT_H changes to a
  // running channel take effect from the next edge.
  assign use_casc = CASCADE_EN && ctrl_q.count_up;
  // >= keeps a shrinking divider from running the prescaler past its limit
  assign ps_tick  = (ps_q >= ps_div_m1(ctrl_q.prescale));
  assign tick     = counting && (use_casc ? cascade_i : ps_tick);
  assign ovf      = tick && (cnt_q == {CNT_W{1'b1}});

  always_comb begin
    ctrl_d   = wr_hi_i ? wr_ctrl : ctrl_q;
    reload_d = wr_lo_i ? wr_data_i : reload_q;
    cnt_d    = cnt_q;
    ps_d     = ps_q;
    irq_d    = ovf && ctrl_q.irq_en;
    if (starting) begin
      // A pending cascade tick is dropped: the channel was stopped this cycle
      cnt_d = reload_q;
      ps_d  = '0;
    end else begin
      if (counting && !use_casc) begin
        ps_d = ps_tick ? '0 : ps_q + 10'd1;
      end
      if (tick) begin
        // Overflow reloads from the pre-write reload value
        cnt_d = ovf ? reload_q : cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      cnt_q    <= '0;
      reload_q <= '0;
      ps_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      ps_q     <= ps_d;
      irq_q    <= irq_d;
    end
  end

  assign count_o = cnt_q;
  assign cnt_h_o = ctrl_to_bits(ctrl_q) & CNT_H_WMASK;
  assign ovf_o   = ovf;
  assign irq_o   = irq_q;

endmodule

// File: rtl/gba_timer_unit.sv
// ---------------------------------------------------------------------------
// gba_timer_unit
// Four-channel GBA hardware timer block (TM0-TM3). One clock edge is one CPU
// cycle. Decodes the halfword register interface, chains channel overflows
// into the next channel's cascade input and returns registered read data.
// Optional: GBA_TIMER_START_DELAY_EN (see gba_timer_channel) adds a 2-cycle
// start latency.
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   wr_en, rd_en   : halfword write / read strobes
//   addr           : {ch[1:0], sel}; sel=0 CNT_L, sel=1 CNT_H
//   wr_data        : write data
//   rd_data        : read data, valid one cycle after rd_en
//   rd_valid       : high one cycle after rd_en
//   irq            : per-channel one-cycle overflow interrupt pulses
// ---------------------------------------------------------------------------
module gba_timer_unit
  import gba_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [2:0]        addr,
  input  logic [15:0]       wr_data,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  output logic [NUM_CH-1:0] irq
);

  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] casc;
  logic [NUM_CH-1:0] wr_lo, wr_hi;
  logic [CNT_W-1:0]  cnt_arr  [NUM_CH];
  logic [15:0]       cnth_arr [NUM_CH];

  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_valid_q;

  // Overflow of channel n-1 is channel n's cascade tick in the same cycle,
  // so a full ch0->ch3 ripple settles combinationally.
  assign casc = {ovf[NUM_CH-2:0], 1'b0};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_lo[g] = wr_en && !addr[0] && (addr[2:1] == 2'(g));
    assign wr_hi[g] = wr_en &&  addr[0] && (addr[2:1] == 2'(g));

    gba_timer_channel #(
      .CNT_W      (CNT_W),
      .CASCADE_EN (g != 0)
    ) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .wr_lo_i   (wr_lo[g]),
      .wr_hi_i   (wr_hi[g]),
      .wr_data_i (wr_data),
      .cascade_i (casc[g]),
      .count_o   (cnt_arr[g]),
      .cnt_h_o   (cnth_arr[g]),
      .ovf_o     (ovf[g]),
      .irq_o     (irq[g])
    );
  end

  // Reads sample pre-edge state, so a same-cycle write is not visible yet.
  always_comb begin
    rd_data_d = addr[0] ? cnth_arr[addr[2:1]] : cnt_arr[addr[2:1]];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_gba_timer_unit.sv
module tb_gba_timer_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_en, rd_en;
  logic [2:0]  addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [3:0]  irq;

  always #5 clock = ~clock;

  gba_timer_unit #(.NUM_CH(4), .CNT_W(16)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .irq      (irq)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q  [$];
  string       name_q [$];
  int          irq_cnt [4] = '{0, 0, 0, 0};

  logic [15:0] mon_exp;
  string       mon_name;

  // Monitor: counts irq pulses and scores every returned read
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) if (irq[i] === 1'b1) irq_cnt[i]++;
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got rd_data=%h, no read outstanding", rd_data);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (rd_data !== mon_exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h", mon_name, rd_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus(input logic w, input logic r, input logic [2:0] a,
                     input logic [15:0] d, input logic [15:0] e, input string nm);
    wr_en   = w;
    rd_en   = r;
    addr    = a;
    wr_data = d;
    if (r) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus(1'b1, 1'b0, a, d, 16'h0, "");
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
    bus(1'b0, 1'b1, a, 16'h0, e, nm);
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  int          snap;
  logic [15:0] dly_exp [4];

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = 3'd0;
    wr_data = 16'h0;

    // Reset values
    repeat (3) tick();
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_rd_valid", 32'(rd_valid), 32'h0);
    check("reset_rd_data", 32'(rd_data), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, $sformatf("reset_reg%0d", i));

    // Prescale /1 wrap on ch0
    do_reset();
    wr(3'd0, 16'hFFFE);
    wr(3'd1, 16'h00C0);
    for (int k = 0; k < 4; k++) begin
      rd(3'd0, (k % 2 == 1) ? 16'hFFFF : 16'hFFFE, $sformatf("ps1_cnt%0d", k));
      check($sformatf("ps1_irq%0d", k), 32'(irq), (k % 2 == 1) ? 32'h1 : 32'h0);
    end

    // Prescale /64 on ch2, irq disabled
    do_reset();
    snap = irq_cnt[2];
    wr(3'd4, 16'h0000);
    wr(3'd5, 16'h0081);
    repeat (63) tick();
    rd(3'd4, 16'h0000, "ps64_cnt63");
    rd(3'd4, 16'h0001, "ps64_cnt64");
    repeat (62) tick();
    rd(3'd4, 16'h0001, "ps64_cnt127");
    rd(3'd4, 16'h0002, "ps64_cnt128");
    rd(3'd5, 16'h0081, "ps64_cnth");
    check("ps64_no_irq", 32'(irq_cnt[2]), 32'(snap));

    // Cascade ch0 -> ch1
    do_reset();
    wr(3'd2, 16'hFFFE);
    wr(3'd3, 16'h00C4);
    wr(3'd0, 16'hFFFF);
    wr(3'd1, 16'h00C0);
    for (int k = 0; k < 4; k++) begin
      rd(3'd2, (k % 2 == 1) ? 16'hFFFF : 16'hFFFE, $sformatf("casc_cnt%0d", k));
      check($sformatf("casc_irq%0d", k), 32'(irq), (k % 2 == 1) ? 32'h3 : 32'h1);
    end

    // CNT_L write on the overflow edge
    do_reset();
    wr(3'd0, 16'hFFF0);
    wr(3'd1, 16'h00C0);
    repeat (15) tick();
    wr(3'd0, 16'h1234);
    check("ovfwr_irq1", 32'(irq), 32'h1);
    rd(3'd0, 16'hFFF0, "ovfwr_old_reload");
    repeat (14) tick();
    rd(3'd0, 16'hFFFF, "ovfwr_pre_ovf");
    check("ovfwr_irq2", 32'(irq), 32'h1);
    rd(3'd0, 16'h1234, "ovfwr_new_reload");

    // Stop written on an overflow tick edge
    do_reset();
    wr(3'd0, 16'hFFFE);
    wr(3'd1, 16'h00C0);
    tick();
    snap = irq_cnt[0];
    wr(3'd1, 16'h0040);
    check("stop_irq", 32'(irq), 32'h0);
    rd(3'd0, 16'hFFFF, "stop_cnt_a");
    rd(3'd0, 16'hFFFF, "stop_cnt_b");
    rd(3'd1, 16'h0040, "stop_cnth");
    check("stop_no_irq", 32'(irq_cnt[0]), 32'(snap));

    // ch0 count-up ignored, CNT_H mask, read/write same register
    do_reset();
    wr(3'd0, 16'h0100);
    wr(3'd1, 16'h0084);
    rd(3'd1, 16'h0084, "ch0_cu_readback");
    rd(3'd0, 16'h0101, "ch0_cu_counts");
    wr(3'd3, 16'hFFFF);
    rd(3'd3, 16'h00C7, "cnth_mask");
    bus(1'b1, 1'b1, 3'd5, 16'h0003, 16'h0000, "rw_same_pre");
    rd(3'd5, 16'h0003, "rw_same_post");

    // Start latency on ch3
`ifdef GBA_TIMER_START_DELAY_EN
    dly_exp = '{16'h0010, 16'h0010, 16'h0010, 16'h0011};
`else
    dly_exp = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
`endif
    do_reset();
    wr(3'd6, 16'h0010);
    wr(3'd7, 16'h0080);
    for (int k = 0; k < 4; k++) rd(3'd6, dly_exp[k], $sformatf("start_cnt%0d", k));

    // Reset on what would be an overflow edge
    do_reset();
    wr(3'd0, 16'hFFFF);
    wr(3'd1, 16'h00C0);
    reset_n = 1'b0;
    tick();
    check("midreset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    rd(3'd0, 16'h0000, "midreset_cnt");
    rd(3'd1, 16'h0000, "midreset_cnth");

    repeat (3) tick();
    check("rd_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gba_timer_unit.md
Name: gba_timer_unit

Overview:
- Four-channel GBA hardware timer block (TM0–TM3), clocked directly by the system `clock` that ClockHandler derives from `master_clock`.
- One `clock` edge equals one GBA CPU cycle.
- Provides the halfword register interface for TMxCNT_L/TMxCNT_H, per-channel prescaling, count-up cascade and overflow interrupt pulses, which go to the interrupt controller.

Parameters:
- NUM_CH, 4, number of channels. Fixed at 4 by the register map; exists only for the generate loop.
- CNT_W, 16, counter and reload width.

Ports:
- clock  input  1  system clock from ClockHandler.
- reset_n  input  1  synchronous, active-low reset.
- wr_en  input  1  halfword register write strobe.
- rd_en  input  1  halfword register read strobe.
- addr  input  3  halfword index: {ch[1:0], sel}. sel=0 selects CNT_L, sel=1 selects CNT_H.
- wr_data  input  16  write data.
- rd_data  output  16  registered read data.
- rd_valid  output  1  high one cycle after rd_en.
- irq  output  4  per-channel overflow interrupt pulse, one cycle wide.

Behaviour:
- Reset is synchronous, active-low. Reset applies all of the following:
  - counters = 0, reload = 0
  - CNT_H fields = 0 (stopped)
  - prescale counters = 0
  - rd_data = 0, rd_valid = 0, irq = 0
- Reset mid-count aborts all activity. No irq is asserted on the reset edge.
- CNT_L write: updates the reload register only. The live counter is untouched.
- CNT_L read: returns the live counter value before the read edge.
- CNT_H layout:
  - [1:0] prescale: 0=/1, 1=/64, 2=/256, 3=/1024
  - [2] count-up
  - [6] irq_en
  - [7] start
  - All other bits are written as ignored and read as 0.
- Count-up is ignored on ch0: it reads back as written but has no effect.
- Start 0→1 write:
  - counter ← reload and prescale counter ← 0 at that edge.
  - Counting begins on the following edge.
- Start 1→1 rewrite: counter is not reloaded. Prescale and irq_en changes take effect on the next edge.
- Start 1→0 write: counter freezes at its current value.
- Tick generation, for a running channel:
  - Count-up channel (ch1–3): a tick is the same-cycle overflow of channel n-1. The prescaler is unused.
  - Otherwise: a tick occurs when the prescale counter reaches (div−1). The prescale counter then wraps to 0.
- On a tick: counter+1. At 0xFFFF the counter wraps to the reload value (not 0), and the channel raises an overflow pulse.
- Overflow pulse: drives irq[n] high for exactly one cycle if irq_en=1. It also feeds the cascade input of channel n+1 combinationally.
- Cascade: a full ripple ch0→ch3 is possible in a single cycle.
- Read latency: rd_data and rd_valid are valid exactly one cycle after rd_en.
- Simultaneous events:
  - CNT_L write coinciding with overflow: the overflow loads the OLD reload value. The new value applies from the next overflow or start.
  - CNT_H write clearing start coinciding with a tick: the stop wins. The counter holds and there is no overflow or irq.
  - Read and write to the same register in one cycle: the read returns the pre-write value.
  - Write to a stopped channel's CNT_H with start=1 while its predecessor overflows in the same cycle: the counter loads the reload value. The cascade tick is ignored that cycle.

Optional Feature:
- Macro: GBA_TIMER_START_DELAY_EN.
- When defined: a 0→1 start loads the counter at the write edge, as without the macro. Counting (prescale advance and cascade acceptance) is then suppressed for 2 further cycles, modelling hardware start latency.
- When undefined: counting begins on the edge immediately after the start write.

Decomposition:
- Package gba_timer_pkg holds:
  - enum prescale_e {PS_1, PS_64, PS_256, PS_1024} and a divider-lookup function
  - CNT_H bit-position localparams: PS_LSB=0, CU_BIT=2, IRQ_BIT=6, START_BIT=7
  - a CNT_H writable-mask constant (16'h00C7)
  - a timer_ctrl_t struct
- Sub-module gba_timer_channel: one channel, containing prescaler, counter, reload, ctrl, cascade_in and overflow_out. The top module instantiates 4 of them, chains cascades, and muxes reads.

Test Plan:
- Reset values: drive reset_n=0 for 3 cycles. Required: irq=0, rd_valid=0, rd_data=0. A read of every CNT_L and CNT_H returns 0x0000.
- Prescale /1 wrap: ch0 reload=0xFFFE, CNT_H=0x00C0.
  - Required: counter reads 0xFFFE, 0xFFFF, 0xFFFE on successive cycles.
  - irq[0] pulses one cycle, on the wrap edge, then repeats every 2 cycles.
- Prescale /64: ch2 reload=0x0000, CNT_H=0x0081. Required: counter =1 after 64 cycles and =2 after 128 cycles. irq[2] never fires (irq_en=0).
- Cascade: ch0 reload=0xFFFF at /1; ch1 reload=0xFFFE, CNT_H=0x00C4.
  - Required: ch1 increments every cycle and overflows every 2nd cycle.
  - irq[1] is seen in the same cycle as the irq[0] pulse that causes it.
- Simultaneous events:
  - Write ch0 CNT_L=0x1234 on the overflow edge of reload 0xFFF0. Required: the counter reloads to 0xFFF0, and the next overflow loads 0x1234.
  - Clear start on a tick edge. Required: the counter is unchanged and no irq.
- Start delay (macro defined): start ch3 with reload=0x0010 at /1. Required: the counter reads 0x0010 for 3 cycles after the write, then 0x0011.
